// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multicycle MIPS datapath: sequences
// fetch/decode/execute/writeback, drives every datapath select and strobe,
// and traps on illegal opcodes or on a memory access that never completes.
module multicycle_ctrl_fsm #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned WAIT_LIMIT = 8,
  parameter bit          ENABLE_MUL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       imm_zext,
  output logic [2:0] alu_op,
  output logic [1:0] pc_src,
  output logic [1:0] mem_to_reg,
  output logic [1:0] reg_dst,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [4:0] state_o
);

  typedef enum logic [4:0] {
    S_FETCH   = 5'd0,
    S_DECODE  = 5'd1,
    S_EXEC_R  = 5'd2,
    S_R_WB    = 5'd3,
    S_ADDI_EX = 5'd4,
    S_SLTI_EX = 5'd5,
    S_ANDI_EX = 5'd6,
    S_ORI_EX  = 5'd7,
    S_I_WB    = 5'd8,
    S_BRANCH  = 5'd9,
    S_JUMP    = 5'd10,
    S_JAL     = 5'd11,
    S_JR      = 5'd12,
    S_MEM_ADR = 5'd13,
    S_MEM_RD  = 5'd14,
    S_MEM_WB  = 5'd15,
    S_MEM_WR  = 5'd16,
    S_MUL_EX  = 5'd17,
    S_TRAP    = 5'd18
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);
  localparam logic [3:0] MUL_LAST  = 4'(MUL_CYCLES - 1);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_wait_cnt;
  logic [3:0] r_mul_cnt;
  logic [1:0] r_trap_cause;
  logic       w_mem_state;
  logic       w_timeout;

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                       (r_state == S_MEM_WR);
  // The limit cycle itself still completes if mem_ready arrives in it.
  assign w_timeout   = w_mem_state && !mem_ready && (r_wait_cnt == WAIT_LAST);

  assign state_o    = r_state;
  assign trap       = (r_state == S_TRAP);
  assign trap_cause = r_trap_cause;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Wait/multiply counters and latched trap cause
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt   <= '0;
      r_mul_cnt    <= '0;
      r_trap_cause <= '0;
    end else begin
      if (w_next != r_state)
        r_wait_cnt <= '0;
      else if (w_mem_state && !mem_ready)
        r_wait_cnt <= r_wait_cnt + 8'd1;

      if (w_next == S_MUL_EX && r_state != S_MUL_EX)
        r_mul_cnt <= MUL_LAST;
      else if (r_state == S_MUL_EX && r_mul_cnt != 4'd0)
        r_mul_cnt <= r_mul_cnt - 4'd1;

      if (w_next == S_TRAP && r_state != S_TRAP)
        r_trap_cause <= (r_state == S_DECODE) ? 2'b01 : 2'b10;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (mem_ready)      w_next = S_DECODE;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_DECODE: begin
        case (opcode)
          6'h00:        w_next = (funct == 6'h08) ? S_JR : S_EXEC_R;
          6'h08, 6'h09: w_next = S_ADDI_EX;
          6'h0a:        w_next = S_SLTI_EX;
          6'h0c:        w_next = S_ANDI_EX;
          6'h0d:        w_next = S_ORI_EX;
          6'h04, 6'h05: w_next = S_BRANCH;
          6'h02:        w_next = S_JUMP;
          6'h03:        w_next = S_JAL;
          6'h23, 6'h2b: w_next = S_MEM_ADR;
          6'h1c:        w_next = (ENABLE_MUL && funct == 6'h02) ? S_MUL_EX : S_TRAP;
          default:      w_next = S_TRAP;
        endcase
      end
      S_EXEC_R:  w_next = S_R_WB;
      S_R_WB:    w_next = S_FETCH;
      S_ADDI_EX, S_SLTI_EX, S_ANDI_EX, S_ORI_EX: w_next = S_I_WB;
      S_I_WB:    w_next = S_FETCH;
      S_BRANCH, S_JUMP, S_JAL, S_JR: w_next = S_FETCH;
      S_MEM_ADR: w_next = (opcode == 6'h2b) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready)      w_next = S_MEM_WB;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_MEM_WB:  w_next = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready)      w_next = S_FETCH;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_MUL_EX:  if (r_mul_cnt == 4'd0) w_next = S_R_WB;
      S_TRAP:    w_next = S_TRAP;
      default:   w_next = S_FETCH;
    endcase
  end

  // Datapath control decode; anything not set for a state stays 0
  always_comb begin
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = '0;
    imm_zext      = 1'b0;
    alu_op        = '0;
    pc_src        = '0;
    mem_to_reg    = '0;
    reg_dst       = '0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:  alu_src_b = 2'b11;
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_SLTI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 3'b100;
      end
      S_ANDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 3'b110;
        imm_zext  = 1'b1;
      end
      S_ORI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 3'b011;
        imm_zext  = 1'b1;
      end
      S_I_WB:    reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b001;
        pc_src        = 2'b01;
        pc_write_cond = 1'b1;
        branch_ne     = (opcode == 6'h05);
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      S_JAL: begin
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
      end
      S_JR: begin
        pc_write = 1'b1;
        pc_src   = 2'b11;
      end
      S_MEM_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
      end
      S_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_MUL_EX: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b101;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: per-cycle state and control
// vectors for each instruction class, memory waits, timeout and mul traps.
module tb_multicycle_ctrl_fsm;

  localparam logic [4:0] S_FETCH = 5'd0, S_DECODE = 5'd1, S_EXEC_R = 5'd2,
    S_R_WB = 5'd3, S_ANDI_EX = 5'd6, S_I_WB = 5'd8, S_BRANCH = 5'd9,
    S_JAL = 5'd11, S_MEM_ADR = 5'd13, S_MEM_RD = 5'd14, S_MEM_WB = 5'd15,
    S_MUL_EX = 5'd17, S_TRAP = 5'd18;

  // ctl = {iord,mem_read,mem_write,ir_write,pc_write,pc_write_cond,branch_ne,
  //        reg_write,alu_src_a, alu_src_b[2], imm_zext, alu_op[3],
  //        pc_src[2], mem_to_reg[2], reg_dst[2]}
  localparam logic [20:0] C_FETCH_W = {9'b010000000, 2'b01, 1'b0, 3'b000, 6'b0};
  localparam logic [20:0] C_FETCH_R = {9'b010110000, 2'b01, 1'b0, 3'b000, 6'b0};
  localparam logic [20:0] C_DECODE  = {9'b000000000, 2'b11, 1'b0, 3'b000, 6'b0};
  localparam logic [20:0] C_EXEC_R  = {9'b000000001, 2'b00, 1'b0, 3'b010, 6'b0};
  localparam logic [20:0] C_R_WB    = {9'b000000010, 2'b00, 1'b0, 3'b000, 2'b00, 2'b00, 2'b01};
  localparam logic [20:0] C_ANDI    = {9'b000000001, 2'b10, 1'b1, 3'b110, 6'b0};
  localparam logic [20:0] C_I_WB    = {9'b000000010, 2'b00, 1'b0, 3'b000, 6'b0};
  localparam logic [20:0] C_BEQ     = {9'b000001001, 2'b00, 1'b0, 3'b001, 2'b01, 4'b0};
  localparam logic [20:0] C_BNE     = {9'b000001101, 2'b00, 1'b0, 3'b001, 2'b01, 4'b0};
  localparam logic [20:0] C_JAL     = {9'b000010010, 2'b00, 1'b0, 3'b000, 2'b10, 2'b10, 2'b10};
  localparam logic [20:0] C_MEM_ADR = {9'b000000001, 2'b10, 1'b0, 3'b000, 6'b0};
  localparam logic [20:0] C_MEM_RD  = {9'b110000000, 2'b00, 1'b0, 3'b000, 6'b0};
  localparam logic [20:0] C_MEM_WB  = {9'b000000010, 2'b00, 1'b0, 3'b000, 2'b00, 2'b01, 2'b00};
  localparam logic [20:0] C_MUL     = {9'b000000001, 2'b00, 1'b0, 3'b101, 6'b0};
  localparam logic [20:0] C_NONE    = 21'b0;

  logic clk, rst_n, mem_ready;
  logic [5:0] opcode, funct;

  logic iord, mem_read, mem_write, ir_write, pc_write, pc_write_cond, branch_ne;
  logic reg_write, alu_src_a, imm_zext, trap;
  logic [1:0] alu_src_b, pc_src, mem_to_reg, reg_dst, trap_cause;
  logic [2:0] alu_op;
  logic [4:0] state_o;
  logic [20:0] ctl;

  logic b_iord, b_mem_read, b_mem_write, b_ir_write, b_pc_write, b_pc_write_cond;
  logic b_branch_ne, b_reg_write, b_alu_src_a, b_imm_zext, b_trap;
  logic [1:0] b_alu_src_b, b_pc_src, b_mem_to_reg, b_reg_dst, b_trap_cause;
  logic [2:0] b_alu_op;
  logic [4:0] b_state_o;
  logic [20:0] b_ctl;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  assign ctl = {iord, mem_read, mem_write, ir_write, pc_write, pc_write_cond, branch_ne,
                reg_write, alu_src_a, alu_src_b, imm_zext, alu_op, pc_src, mem_to_reg, reg_dst};
  assign b_ctl = {b_iord, b_mem_read, b_mem_write, b_ir_write, b_pc_write, b_pc_write_cond,
                  b_branch_ne, b_reg_write, b_alu_src_a, b_alu_src_b, b_imm_zext, b_alu_op,
                  b_pc_src, b_mem_to_reg, b_reg_dst};

  multicycle_ctrl_fsm #(.MUL_CYCLES(4), .WAIT_LIMIT(8), .ENABLE_MUL(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_zext(imm_zext), .alu_op(alu_op), .pc_src(pc_src), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .trap(trap), .trap_cause(trap_cause), .state_o(state_o));

  multicycle_ctrl_fsm #(.MUL_CYCLES(4), .WAIT_LIMIT(8), .ENABLE_MUL(1'b0)) u_nomul (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .iord(b_iord), .mem_read(b_mem_read), .mem_write(b_mem_write), .ir_write(b_ir_write),
    .pc_write(b_pc_write), .pc_write_cond(b_pc_write_cond), .branch_ne(b_branch_ne),
    .reg_write(b_reg_write), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
    .imm_zext(b_imm_zext), .alu_op(b_alu_op), .pc_src(b_pc_src), .mem_to_reg(b_mem_to_reg),
    .reg_dst(b_reg_dst), .trap(b_trap), .trap_cause(b_trap_cause), .state_o(b_state_o));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'h00; funct = 6'h00;
    #3;
    n_total++;
    if ({state_o, ctl, trap, trap_cause} !== {S_FETCH, C_FETCH_W, 1'b0, 2'b00})
      $display("FAIL reset: got state=%0d ctl=%h trap=%b cause=%b, want state=%0d ctl=%h trap=0 cause=00",
               state_o, ctl, trap, trap_cause, S_FETCH, C_FETCH_W);
    else n_pass++;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    logic [4:0]  es [4] = '{S_FETCH, S_DECODE, S_EXEC_R, S_R_WB};
    logic [20:0] ec [4] = '{C_FETCH_R, C_DECODE, C_EXEC_R, C_R_WB};
    opcode = 6'h00; funct = 6'h20; mem_ready = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      #1;
      n_total++;
      if ({state_o, ctl} !== {es[i], ec[i]})
        $display("FAIL rtype step %0d: got state=%0d ctl=%h, want state=%0d ctl=%h",
                 i, state_o, ctl, es[i], ec[i]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_lw_wait();
    logic        mr [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [4:0]  es [9] = '{S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_RD, S_MEM_RD,
                            S_MEM_RD, S_MEM_WB, S_FETCH};
    logic [20:0] ec [9] = '{C_FETCH_R, C_DECODE, C_MEM_ADR, C_MEM_RD, C_MEM_RD, C_MEM_RD,
                            C_MEM_RD, C_MEM_WB, C_FETCH_W};
    opcode = 6'h23; funct = 6'h00;
    for (int unsigned i = 0; i < 9; i++) begin
      mem_ready = mr[i];
      #1;
      n_total++;
      if ({state_o, ctl} !== {es[i], ec[i]})
        $display("FAIL lw_wait step %0d: got state=%0d ctl=%h, want state=%0d ctl=%h",
                 i, state_o, ctl, es[i], ec[i]);
      else n_pass++;
      if (i < 8) tick();
    end
    n_total++;
    if (trap !== 1'b0)
      $display("FAIL lw_no_trap: got trap=%b, want 0", trap);
    else n_pass++;
    tick();
  endtask

  task automatic test_branch();
    logic [5:0]  op [7] = '{6'h04, 6'h04, 6'h04, 6'h05, 6'h05, 6'h05, 6'h00};
    logic [4:0]  es [7] = '{S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_DECODE, S_BRANCH, S_FETCH};
    logic [20:0] ec [7] = '{C_FETCH_R, C_DECODE, C_BEQ, C_FETCH_R, C_DECODE, C_BNE, C_FETCH_W};
    funct = 6'h00;
    for (int unsigned i = 0; i < 7; i++) begin
      opcode = op[i];
      mem_ready = (i < 6);
      #1;
      n_total++;
      if ({state_o, ctl} !== {es[i], ec[i]})
        $display("FAIL branch step %0d: got state=%0d ctl=%h, want state=%0d ctl=%h",
                 i, state_o, ctl, es[i], ec[i]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_jal_andi();
    logic [5:0]  op [8] = '{6'h03, 6'h03, 6'h03, 6'h0c, 6'h0c, 6'h0c, 6'h0c, 6'h00};
    logic [4:0]  es [8] = '{S_FETCH, S_DECODE, S_JAL, S_FETCH, S_DECODE, S_ANDI_EX, S_I_WB, S_FETCH};
    logic [20:0] ec [8] = '{C_FETCH_R, C_DECODE, C_JAL, C_FETCH_R, C_DECODE, C_ANDI, C_I_WB, C_FETCH_W};
    funct = 6'h00;
    for (int unsigned i = 0; i < 8; i++) begin
      opcode = op[i];
      mem_ready = (i < 7);
      #1;
      n_total++;
      if ({state_o, ctl} !== {es[i], ec[i]})
        $display("FAIL jal_andi step %0d: got state=%0d ctl=%h, want state=%0d ctl=%h",
                 i, state_o, ctl, es[i], ec[i]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_mul();
    logic [4:0]  es [8] = '{S_FETCH, S_DECODE, S_MUL_EX, S_MUL_EX, S_MUL_EX, S_MUL_EX,
                            S_R_WB, S_FETCH};
    logic [20:0] ec [8] = '{C_FETCH_R, C_DECODE, C_MUL, C_MUL, C_MUL, C_MUL, C_R_WB, C_FETCH_W};
    opcode = 6'h1c; funct = 6'h02;
    for (int unsigned i = 0; i < 8; i++) begin
      mem_ready = (i < 7);
      #1;
      n_total++;
      if ({state_o, ctl} !== {es[i], ec[i]})
        $display("FAIL mul step %0d: got state=%0d ctl=%h, want state=%0d ctl=%h",
                 i, state_o, ctl, es[i], ec[i]);
      else n_pass++;
      tick();
    end
    n_total++;
    if ({b_state_o, b_ctl, b_trap, b_trap_cause} !== {S_TRAP, C_NONE, 1'b1, 2'b01})
      $display("FAIL mul_disabled: got state=%0d ctl=%h trap=%b cause=%b, want state=%0d ctl=0 trap=1 cause=01",
               b_state_o, b_ctl, b_trap, b_trap_cause, S_TRAP);
    else n_pass++;
  endtask

  task automatic test_timeout_edge();
    rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'h00; funct = 6'h20;
    #2;
    rst_n = 1'b1;
    n_total++;
    if ({b_state_o, b_trap, b_trap_cause} !== {S_FETCH, 1'b0, 2'b00})
      $display("FAIL reset_clears_trap: got state=%0d trap=%b cause=%b, want state=%0d trap=0 cause=00",
               b_state_o, b_trap, b_trap_cause, S_FETCH);
    else n_pass++;
    for (int unsigned i = 0; i < 8; i++) begin
      mem_ready = (i == 7);
      #1;
      n_total++;
      if ({state_o, ctl} !== {S_FETCH, (i == 7) ? C_FETCH_R : C_FETCH_W})
        $display("FAIL limit_edge step %0d: got state=%0d ctl=%h, want state=%0d",
                 i, state_o, ctl, S_FETCH);
      else n_pass++;
      tick();
    end
    #1;
    n_total++;
    if ({state_o, trap} !== {S_DECODE, 1'b0})
      $display("FAIL limit_edge_done: got state=%0d trap=%b, want state=%0d trap=0",
               state_o, trap, S_DECODE);
    else n_pass++;
  endtask

  task automatic test_timeout();
    rst_n = 1'b0; mem_ready = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      #1;
      n_total++;
      if ({state_o, ctl, trap} !== {S_FETCH, C_FETCH_W, 1'b0})
        $display("FAIL timeout_wait step %0d: got state=%0d ctl=%h trap=%b, want state=%0d ctl=%h trap=0",
                 i, state_o, ctl, trap, S_FETCH, C_FETCH_W);
      else n_pass++;
      tick();
    end
    #1;
    n_total++;
    if ({state_o, ctl, trap, trap_cause} !== {S_TRAP, C_NONE, 1'b1, 2'b10})
      $display("FAIL timeout_trap: got state=%0d ctl=%h trap=%b cause=%b, want state=%0d ctl=0 trap=1 cause=10",
               state_o, ctl, trap, trap_cause, S_TRAP);
    else n_pass++;
    mem_ready = 1'b1;
    tick(); tick(); tick();
    n_total++;
    if ({state_o, trap, trap_cause} !== {S_TRAP, 1'b1, 2'b10})
      $display("FAIL trap_sticky: got state=%0d trap=%b cause=%b, want state=%0d trap=1 cause=10",
               state_o, trap, trap_cause, S_TRAP);
    else n_pass++;
    mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({state_o, trap, trap_cause} !== {S_FETCH, 1'b0, 2'b00})
      $display("FAIL trap_reset: got state=%0d trap=%b cause=%b, want state=%0d trap=0 cause=00",
               state_o, trap, trap_cause, S_FETCH);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_branch();
    test_jal_andi();
    test_mul();
    test_timeout_edge();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Second-generation main control FSM for the multicycle MIPS datapath.
- Sequences fetch/decode/execute/writeback and drives all datapath mux selects and write enables.
- Adds over the previous controller: memory ready handshake, parametrised iterative-multiply latency, bne/andi/jr, memory-timeout and illegal-opcode trap, and fully defined (never X) outputs.

Parameters:
- MUL_CYCLES, 4, cycles spent in MUL_EX (1..15).
- WAIT_LIMIT, 8, consecutive mem_ready=0 cycles in a memory state before a bus-timeout trap (1..255).
- ENABLE_MUL, 1, 0 makes opcode 0x1c illegal.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- opcode  in  6  IR[31:26], stable from DECODE until next FETCH
- funct  in  6  IR[5:0]
- mem_ready  in  1  memory completes current access this cycle
- iord  out  1  0=PC, 1=ALUOut address
- mem_read  out  1  read request
- mem_write  out  1  write request
- ir_write  out  1  IR load
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified by zero flag
- branch_ne  out  1  1 inverts zero flag (bne)
- reg_write  out  1  register-file write
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00=B, 01=4, 10=imm, 11=imm<<2
- imm_zext  out  1  1=zero-extend imm, 0=sign-extend
- alu_op  out  3  000 add, 001 sub, 010 funct, 011 or, 100 slt, 101 mul, 110 and
- pc_src  out  2  00=ALU, 01=ALUOut, 10=jump target, 11=rs (jr)
- mem_to_reg  out  2  00=ALUOut, 01=MDR, 10=PC
- reg_dst  out  2  00=rt, 01=rd, 10=r31
- trap  out  1  sticky trap flag
- trap_cause  out  2  01 illegal opcode, 10 memory timeout
- state_o  out  5  current state (debug)

Behaviour:
- State register plus two counters (wait_cnt 8b, mul_cnt 4b), all async reset. Outputs decode combinationally from state, opcode, funct and mem_ready. Any output not listed for a state is 0.
- Reset: state=FETCH, counters=0, trap=0, trap_cause=00. Outputs while in reset are the FETCH values below.
- FETCH: mem_read=1, alu_src_b=01, alu_op=000.
  - ir_write and pc_write are asserted only when mem_ready=1.
  - mem_ready=1 -> DECODE. Otherwise stay.
- DECODE: alu_src_b=11, alu_op=000 (branch target into ALUOut). Dispatch:
  - opcode 0x00: funct 0x08 -> JR, else EXEC_R.
  - 0x08/0x09 -> ADDI_EX; 0x0a -> SLTI_EX; 0x0c -> ANDI_EX; 0x0d -> ORI_EX.
  - 0x04/0x05 -> BRANCH; 0x02 -> JUMP; 0x03 -> JAL; 0x23/0x2b -> MEM_ADR.
  - 0x1c with funct 0x02 and ENABLE_MUL=1 -> MUL_EX.
  - Anything else -> TRAP, cause 01.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=010 -> R_WB.
- R_WB: reg_write=1, reg_dst=01, mem_to_reg=00 -> FETCH.
- Immediate execute states all use alu_src_a=1, alu_src_b=10, then go to I_WB:
  - ADDI_EX: alu_op=000.
  - SLTI_EX: alu_op=100.
  - ANDI_EX: alu_op=110, imm_zext=1.
  - ORI_EX: alu_op=011, imm_zext=1.
- I_WB: reg_write=1, reg_dst=00, mem_to_reg=00 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_src=01, pc_write_cond=1, branch_ne=(opcode==0x05) -> FETCH.
- JUMP: pc_write=1, pc_src=10 -> FETCH.
- JAL: pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10 -> FETCH. The PC written to r31 is the already-incremented PC+4.
- JR: pc_write=1, pc_src=11 -> FETCH.
- MEM_ADR: alu_src_a=1, alu_src_b=10, alu_op=000. Opcode 0x23 -> MEM_RD, 0x2b -> MEM_WR.
- MEM_RD: iord=1, mem_read=1, held until mem_ready=1 -> MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01 -> FETCH.
- MEM_WR: iord=1, mem_write=1, held until mem_ready=1 -> FETCH.
- Timeout (FETCH, MEM_RD, MEM_WR):
  - wait_cnt clears on state entry and increments each cycle mem_ready=0.
  - When it reaches WAIT_LIMIT with mem_ready still 0 -> TRAP, cause 10.
  - mem_ready=1 on the limit cycle completes normally (no trap).
- MUL_EX:
  - mul_cnt loads MUL_CYCLES-1 on entry.
  - alu_src_a=1, alu_src_b=00, alu_op=101 held throughout.
  - Decrement each cycle; at 0 -> R_WB. Residency is exactly MUL_CYCLES cycles.
- TRAP: all strobes 0, trap=1, trap_cause held. Exit only via rst_n.
- Latency with zero-wait memory:
  - 3 cycles: beq/bne/j/jal/jr.
  - 4 cycles: R-type, immediates, sw.
  - 5 cycles: lw.
  - 3+MUL_CYCLES cycles: mul.
- Reset asserted mid-instruction returns to FETCH immediately (async) and cancels any pending write strobe in that cycle.
- Writes never glitch: mem_write/reg_write/pc_write only in the listed states.

Test Plan:
- Reset, then mem_ready=1, opcode=0x00, funct=0x20 -> states FETCH, DECODE, EXEC_R, R_WB. reg_write=1 with reg_dst=01 in cycle 4 only. ir_write/pc_write=1 in cycle 1.
- lw (0x23), mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles with iord=1. MEM_WB follows with mem_to_reg=01. No trap.
- WAIT_LIMIT=8, mem_ready stuck 0 in FETCH -> after 8 cycles state=TRAP, trap=1, trap_cause=10. Stays there until rst_n pulse, after which trap=0.
- bne (0x05) -> BRANCH cycle shows pc_write_cond=1, branch_ne=1, alu_op=001, pc_src=01. beq (0x04) identical with branch_ne=0.
- MUL_CYCLES=4, opcode 0x1c, funct 0x02 -> MUL_EX lasts 4 cycles with alu_op=101, then R_WB. Same instruction with ENABLE_MUL=0 -> TRAP, cause 01.
- jal (0x03) -> single cycle with pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10. andi (0x0c) -> imm_zext=1, alu_op=110.
